// File: rtl/qpi_csr_bank.sv
// qpi_csr_bank: bank of 64-bit host-written CSRs fed by QPI rx0 config writes.
// Each CSR is written as two dword halves. The high-half write commits the
// pair atomically. A CTRL word provides afu_en and a soft-reset pulse. The
// bank also keeps a write counter and a sticky flag for reserved-address writes.
// Pipeline: stage 1 registers the raw rx0 fields. Stage 2 decodes them and
// updates state, so outputs move two edges after cfg_valid is sampled.

// One CSR slot: low-half shadow, committed value, valid/update/pending bits.
module qpi_csr_slot (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        clr,
  input  logic [31:0] data,
  output logic [63:0] value,
  output logic        valid,
  output logic        update,
  output logic        pending
);
  logic [31:0] shadow_lo;

  // Low write parks data in the shadow; high write commits {hi, shadow}.
  // A high write with no fresh low reuses the old shadow on purpose.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      value     <= '0;
      shadow_lo <= '0;
      valid     <= 1'b0;
      update    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      update <= wr_hi;
      if (wr_lo) begin
        shadow_lo <= data;
        pending   <= 1'b1;
      end
      if (wr_hi) begin
        value   <= {data, shadow_lo};
        valid   <= 1'b1;
        pending <= 1'b0;
      end
      // Soft reset drops valid/pending but keeps value and shadow.
      if (clr) begin
        valid   <= 1'b0;
        pending <= 1'b0;
      end
    end
  end
endmodule

module qpi_csr_bank #(
  parameter int          NUM_CSR  = 8,
  parameter logic [11:0] CSR_BASE = 12'h280
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   cfg_valid,
  input  logic [11:0]            cfg_addr,
  input  logic [31:0]            cfg_data,
  output logic [64*NUM_CSR-1:0]  csr_value,
  output logic [NUM_CSR-1:0]     csr_valid,
  output logic [NUM_CSR-1:0]     csr_update,
  output logic                   afu_en,
  output logic                   soft_reset,
  output logic [31:0]            cfg_count,
  output logic                   unmapped_err
);
  localparam int IW       = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam int CTRL_OFF = 2 * NUM_CSR;
  localparam int LAST_OFF = 2 * NUM_CSR + 3;

  if (NUM_CSR < 1 || NUM_CSR > 64) begin : g_bad_num
    $error("qpi_csr_bank: NUM_CSR must be 1..64");
  end
  if (int'(CSR_BASE) + LAST_OFF > 12'hFFF) begin : g_bad_base
    $error("qpi_csr_bank: CSR window runs past 12'hFFF");
  end

  logic        s1_valid;
  logic [11:0] s1_addr;
  logic [31:0] s1_data;

  // Stage 1: plain capture of the rx0 fields, no decode in front of it.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= cfg_valid;
      s1_addr  <= cfg_addr;
      s1_data  <= cfg_data;
    end
  end

  // Stage 2 decode. The offset is taken 13 bits wide so addresses below
  // CSR_BASE cannot alias into the window.
  logic [12:0]        off;
  logic               in_win, is_csr, is_ctrl, is_rsvd, do_sr;
  logic [NUM_CSR-1:0] wr_lo, wr_hi, lo_pending;

  assign off     = {1'b0, s1_addr} - {1'b0, CSR_BASE};
  assign in_win  = s1_valid && (s1_addr >= CSR_BASE) && (off <= 13'(LAST_OFF));
  assign is_csr  = in_win && (off < 13'(CTRL_OFF));
  assign is_ctrl = in_win && (off == 13'(CTRL_OFF));
  assign is_rsvd = in_win && !is_csr && !is_ctrl;
  assign do_sr   = is_ctrl && s1_data[1];

  for (genvar i = 0; i < NUM_CSR; i++) begin : g_slot
    assign wr_lo[i] = is_csr && !off[0] && (off[IW:1] == IW'(i));
    assign wr_hi[i] = is_csr &&  off[0] && (off[IW:1] == IW'(i));

    qpi_csr_slot u_slot (
      .clk     (clk),
      .resetb  (resetb),
      .wr_lo   (wr_lo[i]),
      .wr_hi   (wr_hi[i]),
      .clr     (do_sr),
      .data    (s1_data),
      .value   (csr_value[64*i +: 64]),
      .valid   (csr_valid[i]),
      .update  (csr_update[i]),
      .pending (lo_pending[i])
    );
  end

  // lo_pending is bookkeeping visible in the hierarchy only; nothing consumes it.
  logic unused_pending;
  assign unused_pending = ^lo_pending;

  // Control word, write counter and sticky reserved-address flag.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      afu_en       <= 1'b0;
      soft_reset   <= 1'b0;
      cfg_count    <= '0;
      unmapped_err <= 1'b0;
    end else begin
      soft_reset <= do_sr;
      if (is_ctrl) afu_en <= s1_data[0];
      if (in_win)  cfg_count <= cfg_count + 32'd1;
      if (is_rsvd) unmapped_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qpi_csr_bank.sv
// Bench for qpi_csr_bank: a reference model runs as stimulus is driven.
// Expected snapshots queue up and are compared two cycles later, when the
// DUT shows them. Constant checks pin the directed scenarios.
module tb_qpi_csr_bank;
  localparam int          N    = 8;
  localparam logic [11:0] BASE = 12'h280;

  logic               clk = 1'b0;
  logic               resetb = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [11:0]        cfg_addr = '0;
  logic [31:0]        cfg_data = '0;
  logic [64*N-1:0]    csr_value;
  logic [N-1:0]       csr_valid, csr_update;
  logic               afu_en, soft_reset, unmapped_err;
  logic [31:0]        cfg_count;

  always #5 clk = ~clk;

  qpi_csr_bank #(.NUM_CSR(N), .CSR_BASE(BASE)) dut (
    .clk(clk), .resetb(resetb), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .csr_value(csr_value), .csr_valid(csr_valid),
    .csr_update(csr_update), .afu_en(afu_en), .soft_reset(soft_reset),
    .cfg_count(cfg_count), .unmapped_err(unmapped_err)
  );

  typedef struct packed {
    logic [64*N-1:0] value;
    logic [N-1:0]    valid;
    logic [N-1:0]    update;
    logic            afu;
    logic            sr;
    logic [31:0]     count;
    logic            err;
  } snap_t;

  snap_t       q[$];
  logic [63:0] mval[N];
  logic [31:0] msh[N];
  logic [N-1:0] mvalid;
  logic        mafu, merr;
  logic [31:0] mcount;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input snap_t s);
    chk("csr_value", 512'(csr_value), 512'(s.value));
    chk("csr_valid", 512'(csr_valid), 512'(s.valid));
    chk("csr_update", 512'(csr_update), 512'(s.update));
    chk("afu_en", 512'(afu_en), 512'(s.afu));
    chk("soft_reset", 512'(soft_reset), 512'(s.sr));
    chk("cfg_count", 512'(cfg_count), 512'(s.count));
    chk("unmapped_err", 512'(unmapped_err), 512'(s.err));
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mval[i] = '0;
      msh[i]  = '0;
    end
    mvalid = '0; mafu = 1'b0; merr = 1'b0; mcount = '0;
  endfunction

  // Applies one write to the model and returns the state it should produce.
  function automatic snap_t model_apply(input logic v, input logic [11:0] a, input logic [31:0] d);
    snap_t s;
    int off, idx;
    s.update = '0;
    s.sr     = 1'b0;
    if (v) begin
      off = int'(a) - int'(BASE);
      if (off >= 0 && off <= 2*N+3) begin
        $display("cfg write byte_addr=%h data=%h", {a, 2'b00}, d);
        mcount = mcount + 32'd1;
        if (off < 2*N) begin
          idx = off / 2;
          if (off % 2 == 0) msh[idx] = d;
          else begin
            mval[idx] = {d, msh[idx]};
            mvalid[idx] = 1'b1;
            s.update[idx] = 1'b1;
          end
        end else if (off == 2*N) begin
          mafu = d[0];
          if (d[1]) begin
            mvalid = '0;
            s.sr = 1'b1;
          end
        end else merr = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) s.value[64*i +: 64] = mval[i];
    s.valid = mvalid; s.afu = mafu; s.count = mcount; s.err = merr;
    return s;
  endfunction

  // One cycle: check what the DUT shows now, then drive the next input.
  task automatic step(input logic rn, input logic v, input logic [11:0] a, input logic [31:0] d);
    snap_t s;
    @(negedge clk);
    if (q.size() == 2) begin
      s = q.pop_front();
      cmp(s);
    end
    resetb = rn; cfg_valid = v; cfg_addr = a; cfg_data = d;
    if (!rn) begin
      model_reset();
      s = model_apply(1'b0, '0, '0);
      q.delete();
      q.push_back(s);
      q.push_back(s);
    end else begin
      s = model_apply(v, a, d);
      q.push_back(s);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    idle(); idle();
    chk("rst_value", 512'(csr_value), 512'(0));
    chk("rst_count", 512'(cfg_count), 512'(0));

    // Low then high back-to-back on CSR 2.
    wr(BASE + 12'd4, 32'h1111_2222);
    wr(BASE + 12'd5, 32'h3333_4444);
    idle(); idle();
    chk("csr2_value", 512'(csr_value[128 +: 64]), 512'(64'h3333_4444_1111_2222));
    chk("csr2_update", 512'(csr_update), 512'(8'h04));
    chk("csr2_valid", 512'(csr_valid), 512'(8'h04));
    chk("csr2_count", 512'(cfg_count), 512'(2));
    idle();
    chk("csr2_update_once", 512'(csr_update), 512'(0));

    // Low alone does not commit; high-only rewrite reuses the shadow.
    wr(BASE, 32'hAAAA_AAAA);
    idle(); idle();
    chk("csr0_lo_only", 512'(csr_value[63:0]), 512'(0));
    chk("csr0_lo_valid", 512'(csr_valid[0]), 512'(0));
    wr(BASE + 12'd1, 32'h5);
    idle(); idle();
    chk("csr0_hi5", 512'(csr_value[63:0]), 512'(64'h5_AAAA_AAAA));
    wr(BASE + 12'd1, 32'h6);
    idle(); idle();
    chk("csr0_hi6", 512'(csr_value[63:0]), 512'(64'h6_AAAA_AAAA));
    chk("csr0_upd2", 512'(csr_update[0]), 512'(1));

    // Soft reset via CTRL keeps values, clears valid.
    wr(BASE + 12'd2, 32'hBEEF_0001);
    wr(BASE + 12'd3, 32'hCAFE_0002);
    wr(BASE + 12'd16, 32'h3);
    idle(); idle();
    chk("sr_afu", 512'(afu_en), 512'(1));
    chk("sr_pulse", 512'(soft_reset), 512'(1));
    chk("sr_valid", 512'(csr_valid), 512'(0));
    chk("sr_keep0", 512'(csr_value[63:0]), 512'(64'h6_AAAA_AAAA));
    chk("sr_keep1", 512'(csr_value[127:64]), 512'(64'hCAFE_0002_BEEF_0001));
    idle();
    chk("sr_pulse_end", 512'(soft_reset), 512'(0));

    // Soft reset immediately followed by a commit: the commit survives.
    wr(BASE + 12'd16, 32'h2);
    wr(BASE + 12'd5, 32'h7777_0000);
    idle(); idle(); idle();
    chk("sr_then_wr", 512'(csr_valid), 512'(8'h04));
    chk("sr_afu_off", 512'(afu_en), 512'(0));

    // Reserved address sets the sticky flag; out-of-window writes are ignored.
    wr(BASE + 12'd18, 32'h1234);
    wr(BASE - 12'd1, 32'hFFFF_FFFF);
    wr(BASE + 12'd20, 32'hFFFF_FFFF);
    idle(); idle();
    chk("rsvd_err", 512'(unmapped_err), 512'(1));
    chk("oow_count", 512'(cfg_count), 512'(11));

    // Reset one cycle after a high-half write drops the in-flight commit.
    wr(BASE + 12'd7, 32'h9999_9999);
    step(1'b0, 1'b0, '0, '0);
    idle(); idle();
    chk("rst_drop_value", 512'(csr_value), 512'(0));
    chk("rst_drop_valid", 512'(csr_valid), 512'(0));
    chk("rst_drop_count", 512'(cfg_count), 512'(0));
    chk("rst_drop_err", 512'(unmapped_err), 512'(0));

    // Random back-to-back traffic around and inside the window.
    for (int k = 0; k < 1000; k++) begin
      logic [11:0] a;
      a = 12'(int'(BASE) - 2 + int'($urandom_range(0, 2*N+7)));
      step(1'b1, $urandom_range(0, 9) != 0, a, $urandom);
    end

    // Counter wrap at 2^32.
    idle(); idle();
    force dut.cfg_count = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    for (int k = 0; k < q.size(); k++) q[k].count = 32'hFFFF_FFFF;
    idle();
    release dut.cfg_count;
    wr(BASE + 12'd18, 32'h0);
    idle(); idle();
    chk("count_wrap", 512'(cfg_count), 512'(0));
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
